// File: rtl/ascon_ctrl.sv
// Ascon-128 encryption control: phase sequencing, round counter and
// datapath strobes for a round-per-cycle permutation.
module ascon_ctrl #(
   parameter int ROUND_WIDTH = 4,
   parameter int PA_ROUNDS   = 12,
   parameter int PB_ROUNDS   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic                   no_ad_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic                   ad_valid_i,
   output logic                   ad_ready_o,
   input  logic                   ad_last_i,
   input  logic                   pt_valid_i,
   output logic                   pt_ready_o,
   input  logic                   pt_last_i,
   output logic                   en_state_o,
   output logic                   sel_ad_o,
   output logic                   sel_state_init_o,
   output logic                   sel_xor_init_o,
   output logic                   sel_xor_ext_o,
   output logic                   sel_xor_dom_sep_o,
   output logic                   sel_xor_fin_o,
   output logic                   sel_xor_tag_o,
   output logic                   ct_valid_o,
   output logic                   tag_valid_o,
   output logic [ROUND_WIDTH-1:0] rnd_o
);

   typedef enum logic [2:0] {
      IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, TAG
   } state_t;

   localparam logic [ROUND_WIDTH-1:0] RND_LAST = ROUND_WIDTH'(PA_ROUNDS - 1);
   localparam logic [ROUND_WIDTH-1:0] RND_PB   = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS);
   localparam logic [ROUND_WIDTH-1:0] RND_PB1  = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS + 1);
   localparam logic [ROUND_WIDTH-1:0] RND_ONE  = ROUND_WIDTH'(1);

   state_t                 state;
   logic [ROUND_WIDTH-1:0] rnd;
   logic                   no_ad;
   logic                   ad_last;
   logic                   rnd_end;

   assign rnd_end = (rnd == RND_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rnd     <= '0;
         no_ad   <= 1'b0;
         ad_last <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               rnd <= '0;
               if (start_i) begin
                  no_ad <= no_ad_i;
                  state <= INIT;
               end
            end
            INIT: begin
               if (rnd_end) begin
                  rnd   <= RND_PB;
                  state <= no_ad ? PT_WAIT : AD_WAIT;
               end else begin
                  rnd <= rnd + RND_ONE;
               end
            end
            AD_WAIT: begin
               if (ad_valid_i) begin
                  ad_last <= ad_last_i;
                  rnd     <= RND_PB1;
                  state   <= AD_PERM;
               end
            end
            AD_PERM: begin
               if (rnd_end) begin
                  rnd   <= RND_PB;
                  state <= ad_last ? PT_WAIT : AD_WAIT;
               end else begin
                  rnd <= rnd + RND_ONE;
               end
            end
            PT_WAIT: begin
               if (pt_valid_i) begin
                  rnd   <= pt_last_i ? RND_ONE : RND_PB1;
                  state <= pt_last_i ? FINAL : PT_PERM;
               end
            end
            PT_PERM: begin
               if (rnd_end) begin
                  rnd   <= RND_PB;
                  state <= PT_WAIT;
               end else begin
                  rnd <= rnd + RND_ONE;
               end
            end
            FINAL: begin
               if (rnd_end) begin
                  rnd   <= '0;
                  state <= TAG;
               end else begin
                  rnd <= rnd + RND_ONE;
               end
            end
            TAG: begin
               rnd   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Moore strobes follow state/rnd; WAIT-state strobes follow the valid inputs
   always_comb begin
      busy_o            = (state != IDLE);
      done_o            = 1'b0;
      ad_ready_o        = 1'b0;
      pt_ready_o        = 1'b0;
      en_state_o        = 1'b0;
      sel_ad_o          = 1'b0;
      sel_state_init_o  = 1'b0;
      sel_xor_init_o    = 1'b0;
      sel_xor_ext_o     = 1'b0;
      sel_xor_dom_sep_o = 1'b0;
      sel_xor_fin_o     = 1'b0;
      sel_xor_tag_o     = 1'b0;
      ct_valid_o        = 1'b0;
      tag_valid_o       = 1'b0;
      rnd_o             = rnd;
      unique case (state)
         IDLE: ;
         INIT: begin
            en_state_o        = 1'b1;
            sel_state_init_o  = (rnd == '0);
            sel_xor_init_o    = rnd_end;
            sel_xor_dom_sep_o = rnd_end & no_ad;
         end
         AD_WAIT: begin
            ad_ready_o    = 1'b1;
            en_state_o    = ad_valid_i;
            sel_ad_o      = ad_valid_i;
            sel_xor_ext_o = ad_valid_i;
         end
         AD_PERM: begin
            en_state_o        = 1'b1;
            sel_xor_dom_sep_o = rnd_end & ad_last;
         end
         PT_WAIT: begin
            pt_ready_o    = 1'b1;
            en_state_o    = pt_valid_i;
            sel_xor_ext_o = pt_valid_i;
            ct_valid_o    = pt_valid_i;
            sel_xor_fin_o = pt_valid_i & pt_last_i;
            if (pt_valid_i && pt_last_i)
               rnd_o = '0;
         end
         PT_PERM: en_state_o = 1'b1;
         FINAL: begin
            en_state_o    = 1'b1;
            sel_xor_tag_o = rnd_end;
         end
         TAG: begin
            tag_valid_o = 1'b1;
            done_o      = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Self-checking bench for ascon_ctrl: directed phases plus random traffic
// against a schedule-based reference of expected per-cycle strobes.
module tb_ascon_ctrl;

   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst;
   logic start_i, no_ad_i;
   logic ad_valid_i, ad_last_i, pt_valid_i, pt_last_i;
   logic busy_o, done_o, ad_ready_o, pt_ready_o, en_state_o, sel_ad_o;
   logic sel_state_init_o, sel_xor_init_o, sel_xor_ext_o, sel_xor_dom_sep_o;
   logic sel_xor_fin_o, sel_xor_tag_o, ct_valid_o, tag_valid_o;
   logic [RW-1:0] rnd_o;

   always #5 clk = ~clk;

   ascon_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start_i), .no_ad_i(no_ad_i),
      .busy_o(busy_o), .done_o(done_o),
      .ad_valid_i(ad_valid_i), .ad_ready_o(ad_ready_o), .ad_last_i(ad_last_i),
      .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_last_i(pt_last_i),
      .en_state_o(en_state_o), .sel_ad_o(sel_ad_o),
      .sel_state_init_o(sel_state_init_o), .sel_xor_init_o(sel_xor_init_o),
      .sel_xor_ext_o(sel_xor_ext_o), .sel_xor_dom_sep_o(sel_xor_dom_sep_o),
      .sel_xor_fin_o(sel_xor_fin_o), .sel_xor_tag_o(sel_xor_tag_o),
      .ct_valid_o(ct_valid_o), .tag_valid_o(tag_valid_o), .rnd_o(rnd_o)
   );

   // expected cycle record; mode after the last queued record empties
   typedef struct {
      bit [13:0] o;
      int        rnd;
      bit        chk_rnd;
      int        after;
   } rec_t;

   localparam int M_IDLE = 0, M_AD = 1, M_PT = 2;

   rec_t q[$];
   int   mode;
   int   total, bad;
   int   cyc, tag_cyc, ct_cnt;
   int   n_ad, n_pt, ad_sent, pt_sent;

   function automatic bit [13:0] pk(bit busy, bit done, bit adr, bit ptr,
      bit en, bit sad, bit ini, bit xin, bit ext, bit dom, bit xfin,
      bit xtag, bit ct, bit tag);
      return {busy, done, adr, ptr, en, sad, ini, xin, ext, dom, xfin,
              xtag, ct, tag};
   endfunction

   function automatic rec_t mk(int r, bit chk, bit ini, bit xin, bit dom,
      bit xtag, bit tag, int after);
      rec_t x;
      x.o = pk(1, tag, 0, 0, !tag, 0, ini, xin, 0, dom, 0, xtag, 0, tag);
      x.rnd = r;
      x.chk_rnd = chk;
      x.after = after;
      return x;
   endfunction

   function automatic bit [13:0] actual();
      return pk(busy_o, done_o, ad_ready_o, pt_ready_o, en_state_o, sel_ad_o,
                sel_state_init_o, sel_xor_init_o, sel_xor_ext_o,
                sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o, ct_valid_o,
                tag_valid_o);
   endfunction

   task automatic check_outputs();
      bit [13:0] eo;
      int er;
      bit ck, b;
      eo = '0; er = 0; ck = 1'b1;
      if (q.size() > 0) begin
         eo = q[0].o; er = q[0].rnd; ck = q[0].chk_rnd;
      end else if (mode == M_AD) begin
         b = ad_valid_i;
         eo = pk(1, 0, 1, 0, b, b, 0, 0, b, 0, 0, 0, 0, 0);
         er = 6;
      end else if (mode == M_PT) begin
         b = pt_valid_i;
         eo = pk(1, 0, 0, 1, b, 0, 0, 0, b, 0, b & pt_last_i, 0, b, 0);
         er = (b && pt_last_i) ? 0 : 6;
      end
      total++;
      assert (actual() === eo) else begin
         bad++;
         $error("FAIL outs cyc=%0d got=%b exp=%b", cyc, actual(), eo);
      end
      if (ck) begin
         total++;
         assert (rnd_o === RW'(er)) else begin
            bad++;
            $error("FAIL rnd cyc=%0d got=%0d exp=%0d", cyc, rnd_o, er);
         end
      end
   endtask

   task automatic advance_model();
      rec_t r;
      if (q.size() > 0) begin
         r = q.pop_front();
         if (q.size() == 0) mode = r.after;
      end else if (mode == M_IDLE && start_i) begin
         for (int i = 0; i < 12; i++)
            q.push_back(mk(i, 1, i == 0, i == 11, (i == 11) && no_ad_i, 0, 0,
                           no_ad_i ? M_PT : M_AD));
      end else if (mode == M_AD && ad_valid_i) begin
         ad_sent++;
         for (int i = 7; i <= 11; i++)
            q.push_back(mk(i, 1, 0, 0, (i == 11) && ad_last_i, 0, 0,
                           ad_last_i ? M_PT : M_AD));
      end else if (mode == M_PT && pt_valid_i) begin
         pt_sent++;
         if (pt_last_i) begin
            for (int i = 1; i <= 11; i++)
               q.push_back(mk(i, 1, 0, 0, 0, i == 11, 0, M_IDLE));
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1, M_IDLE));
         end else begin
            for (int i = 7; i <= 11; i++)
               q.push_back(mk(i, 1, 0, 0, 0, 0, 0, M_PT));
         end
      end
   endtask

   // one clock: inputs already set at edge+1; check at edge+2
   task automatic step();
      ad_last_i = (ad_sent + 1 == n_ad);
      pt_last_i = (pt_sent + 1 == n_pt);
      #1;
      check_outputs();
      if (tag_valid_o && tag_cyc < 0) tag_cyc = cyc;
      if (ct_valid_o) ct_cnt++;
      advance_model();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_msg(bit noad, int nad, int npt);
      no_ad_i = noad;
      n_ad = nad; n_pt = npt;
      ad_sent = 0; pt_sent = 0;
      tag_cyc = -1; ct_cnt = 0;
   endtask

   task automatic run_to_idle(int budget);
      int i;
      i = 0;
      while ((q.size() > 0 || mode != M_IDLE) && i < budget) begin
         step();
         i++;
      end
      total++;
      assert (q.size() == 0 && mode == M_IDLE) else begin
         bad++;
         $error("FAIL timeout got=busy exp=idle within %0d", budget);
      end
   endtask

   task automatic check_int(string tag, int got, int exp);
      total++;
      assert (got == exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_int("rst_outs", int'(actual()), 0);
      check_int("rst_rnd", int'(rnd_o), 0);
      q.delete();
      mode = M_IDLE;
      @(posedge clk);
      #1;
      cyc++;
      check_int("rst_hold", int'(actual()), 0);
      rst = 1'b0;
   endtask

   int t0;

   initial begin
      total = 0; bad = 0; cyc = 0; mode = M_IDLE;
      rst = 1'b1; start_i = 0; no_ad_i = 0;
      ad_valid_i = 0; ad_last_i = 0; pt_valid_i = 0; pt_last_i = 0;
      begin_msg(0, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      do_reset();

      // no AD, single PT, sources always valid
      begin_msg(1, 0, 1);
      ad_valid_i = 1; pt_valid_i = 1;
      t0 = cyc; start_i = 1; step(); start_i = 0;
      run_to_idle(60);
      check_int("noad_tag_cyc", tag_cyc - t0, 25);
      check_int("noad_ct_cnt", ct_cnt, 1);

      // one AD, one PT
      begin_msg(0, 1, 1);
      t0 = cyc; start_i = 1; step(); start_i = 0;
      run_to_idle(60);
      check_int("ad1_tag_cyc", tag_cyc - t0, 31);

      // backpressure, stray pt_valid in AD_WAIT, start during INIT
      begin_msg(0, 1, 1);
      ad_valid_i = 0; pt_valid_i = 1;
      t0 = cyc; start_i = 1; step();
      for (int i = 0; i < 12; i++) step();
      start_i = 0;
      for (int i = 0; i < 4; i++) step();
      ad_valid_i = 1;
      run_to_idle(60);
      check_int("bp_tag_cyc", tag_cyc - t0, 35);

      // two AD, two PT
      begin_msg(0, 2, 2);
      t0 = cyc; start_i = 1; step(); start_i = 0;
      run_to_idle(80);
      check_int("ad2_tag_cyc", tag_cyc - t0, 43);
      check_int("ad2_ct_cnt", ct_cnt, 2);

      // reset mid-FINAL at rnd=5, then a clean restart
      begin_msg(1, 0, 1);
      start_i = 1; step(); start_i = 0;
      for (int i = 0; i < 17; i++) step();
      check_int("pre_rst_rnd", int'(rnd_o), 5);
      do_reset();
      begin_msg(1, 0, 1);
      t0 = cyc; start_i = 1; step(); start_i = 0;
      run_to_idle(60);
      check_int("restart_tag_cyc", tag_cyc - t0, 25);

      // random traffic with stray valids/starts and occasional reset
      for (int c = 0; c < 3000; c++) begin
         if (q.size() == 0 && mode == M_IDLE) begin
            start_i = ($urandom_range(3) == 0);
            if (start_i) begin
               no_ad_i = $urandom_range(1);
               begin_msg(no_ad_i, no_ad_i ? 0 : 1 + $urandom_range(2),
                         1 + $urandom_range(2));
            end
         end else begin
            start_i = ($urandom_range(7) == 0);
            no_ad_i = $urandom_range(1);
         end
         ad_valid_i = ($urandom_range(2) != 0);
         pt_valid_i = ($urandom_range(2) != 0);
         if ($urandom_range(399) == 0) begin
            do_reset();
            start_i = 0;
         end
         step();
      end
      start_i = 0;
      ad_valid_i = 1; pt_valid_i = 1;
      run_to_idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
